// File: rtl/cernbe_fifo_target_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cernbe_fifo_target_pkg                                                     |
// | Register map, field positions and read-pipeline states for the target.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cernbe_fifo_target_pkg;

  localparam logic [10:0] ADDR_STATUS  = 11'd0;
  localparam logic [10:0] ADDR_CONTROL = 11'd1;
  localparam logic [10:0] ADDR_DATA    = 11'd2;
  localparam logic [10:0] ADDR_OVF     = 11'd3;

  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;
  localparam int STATUS_OVF_BIT   = 18;

  localparam int CTRL_CLEAR_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_OVF_CLR_BIT = 2;
  localparam int CTRL_THR_LSB     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/cernbe_fifo_target_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cernbe_fifo_target_if                                                      |
// | CERN-BE submap bus between memory-map decoder (master) and target (slave).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cernbe_fifo_target_if;

  logic [12:2] VMEAddr;
  logic [31:0] VMERdData;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic        VMERdDone;
  logic        VMEWrDone;
  logic        VMERdError;
  logic        VMEWrError;

  modport master (
    output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
  );

  modport slave (
    input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
    output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
  );

endinterface
`default_nettype wire

// File: rtl/cernbe_fifo_target_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cernbe_fifo_target_ram                                                     |
// | Simple dual-port RAM: synchronous write, registered read.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cernbe_fifo_target_ram #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/cernbe_fifo_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cernbe_fifo_target                                                         |
// | Bus-readable FIFO target with status/control, threshold IRQ and optional  |
// | overflow counter (enabled by defining FIFO_TARGET_OVF_CNT_EN).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cernbe_fifo_target
  import cernbe_fifo_target_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                      Clk,
  input  logic                      Rst,
  cernbe_fifo_target_if.slave       bus,
  input  logic                      push_i,
  input  logic [31:0]               push_data_i,
  output logic                      full_o,
  output logic                      irq_o
);

  localparam int                LVL_W   = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]  LVL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  rd_state_t               state, state_nxt;
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        level, level_nxt;
  logic                    empty_r, full_r, ovf_r, irq_r;
  logic                    irq_en;
  logic [15:0]             threshold;
  logic                    rd_err_r;
  logic [31:0]             ram_q;

  logic                    rd_done, rd_error, wr_done, wr_error;
  logic [31:0]             rd_data;

  logic [10:0]             addr;
  logic                    rd_stb, wr_stb, data_rd, pop, ctrl_wr, clear, ovf_clr;
  logic                    push_ok, push_drop;
  logic [31:0]             status_word, reg_rdata;
  logic                    reg_rerr;
  logic                    unused_wr_bits;

  assign addr      = bus.VMEAddr;
  assign rd_stb    = bus.VMERdMem & (state == IDLE);
  assign wr_stb    = bus.VMEWrMem & (state == IDLE);
  assign data_rd   = rd_stb & (addr == ADDR_DATA);
  assign pop       = data_rd & ~empty_r;
  assign ctrl_wr   = wr_stb & (addr == ADDR_CONTROL);
  assign clear     = ctrl_wr & bus.VMEWrData[CTRL_CLEAR_BIT];
  assign ovf_clr   = ctrl_wr & bus.VMEWrData[CTRL_OVF_CLR_BIT];
  // Push acceptance looks only at the registered full flag; clear swallows pushes.
  assign push_ok   = push_i & ~full_r & ~clear;
  assign push_drop = push_i &  full_r & ~clear;
  assign level_nxt = level + LVL_W'(push_ok) - LVL_W'(pop);
  assign unused_wr_bits = ^bus.VMEWrData[15:3];

  cernbe_fifo_target_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_ram (
    .clk     (Clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (push_data_i),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_rd) state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level   <= level_nxt;
      empty_r <= (level_nxt == '0);
      full_r  <= (level_nxt == LVL_MAX);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_r     <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
      irq_r     <= 1'b0;
      rd_err_r  <= 1'b0;
    end else begin
      // A drop in the same cycle as ovf_clr keeps the sticky bit set.
      if (push_drop)    ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
      if (ctrl_wr) begin
        irq_en    <= bus.VMEWrData[CTRL_IRQ_EN_BIT];
        threshold <= bus.VMEWrData[31:CTRL_THR_LSB];
      end
      irq_r <= irq_en & (16'(level) >= threshold) & (threshold != 16'd0);
      if (data_rd) rd_err_r <= empty_r;
    end
  end

`ifdef FIFO_TARGET_OVF_CNT_EN
  logic [15:0] ovf_cnt;

  always_ff @(posedge Clk) begin
    if (Rst)                                   ovf_cnt <= '0;
    else if (push_drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  always_comb begin
    status_word                   = '0;
    status_word[LVL_W-1:0]        = level;
    status_word[STATUS_EMPTY_BIT] = empty_r;
    status_word[STATUS_FULL_BIT]  = full_r;
    status_word[STATUS_OVF_BIT]   = ovf_r;
  end

  always_comb begin
    reg_rdata = '0;
    reg_rerr  = 1'b0;
    case (addr)
      ADDR_STATUS:  reg_rdata = status_word;
      ADDR_CONTROL: begin
        reg_rdata[CTRL_IRQ_EN_BIT]  = irq_en;
        reg_rdata[31:CTRL_THR_LSB]  = threshold;
      end
`ifdef FIFO_TARGET_OVF_CNT_EN
      ADDR_OVF:     reg_rdata = {16'd0, ovf_cnt};
`endif
      default:      reg_rerr = 1'b1;
    endcase
  end

  // Only CONTROL is writable; everything else completes with an error.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_done  <= 1'b0;
      rd_error <= 1'b0;
      rd_data  <= '0;
      wr_done  <= 1'b0;
      wr_error <= 1'b0;
    end else begin
      wr_done  <= wr_stb;
      wr_error <= wr_stb & (addr != ADDR_CONTROL);
      rd_done  <= 1'b0;
      rd_error <= 1'b0;
      rd_data  <= '0;
      if (rd_stb && (addr != ADDR_DATA)) begin
        rd_done  <= 1'b1;
        rd_error <= reg_rerr;
        rd_data  <= reg_rdata;
      end else if (state == RD1) begin
        rd_done  <= 1'b1;
        rd_error <= rd_err_r;
        rd_data  <= rd_err_r ? 32'd0 : ram_q;
      end
    end
  end

  assign bus.VMERdData  = rd_data;
  assign bus.VMERdDone  = rd_done;
  assign bus.VMERdError = rd_error;
  assign bus.VMEWrDone  = wr_done;
  assign bus.VMEWrError = wr_error;
  assign full_o         = full_r;
  assign irq_o          = irq_r;

endmodule
`default_nettype wire

// File: tb/tb_cernbe_fifo_target.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cernbe_fifo_target                                                      |
// | Directed self-checking bench for cernbe_fifo_target with a 4-word FIFO.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cernbe_fifo_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [31:0] push_data = '0;
  logic        full;
  logic        irq;
  int          errors = 0;
  int          checks = 0;

  cernbe_fifo_target_if bus_if ();

  cernbe_fifo_target #(.DEPTH_LOG2(2)) dut (
    .Clk         (clk),
    .Rst         (rst),
    .bus         (bus_if.slave),
    .push_i      (push),
    .push_data_i (push_data),
    .full_o      (full),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_read(input logic [10:0] a, output logic [31:0] d, output logic e, output int lat);
    bus_if.VMEAddr  = a;
    bus_if.VMERdMem = 1'b1;
    @(posedge clk); #1;
    bus_if.VMERdMem = 1'b0;
    lat = 1;
    while (bus_if.VMERdDone !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    d = bus_if.VMERdData;
    e = bus_if.VMERdError;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [10:0] a, input logic [31:0] d, output logic done, output logic e);
    bus_if.VMEAddr   = a;
    bus_if.VMEWrData = d;
    bus_if.VMEWrMem  = 1'b1;
    @(posedge clk); #1;
    bus_if.VMEWrMem  = 1'b0;
    done = bus_if.VMEWrDone;
    e    = bus_if.VMEWrError;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    push      = 1'b1;
    push_data = d;
    @(posedge clk); #1;
    push      = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({full, irq, bus_if.VMERdDone, bus_if.VMEWrDone, bus_if.VMERdError, bus_if.VMEWrError} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000",
        {full, irq, bus_if.VMERdDone, bus_if.VMEWrDone, bus_if.VMERdError, bus_if.VMEWrError});
    end
    checks++;
    if (bus_if.VMERdData !== 32'd0) begin errors++; $display("FAIL reset_rddata: got %h expected 0", bus_if.VMERdData); end
    bus_read(11'd0, d, e, lat);
    checks++;
    if (lat !== 1 || d !== 32'h0001_0000 || e !== 1'b0) begin
      errors++; $display("FAIL reset_status: lat=%0d data=%h err=%b expected lat=1 data=00010000 err=0", lat, d, e);
    end
    bus_read(11'd2, d, e, lat);
    checks++;
    if (lat !== 2 || d !== 32'd0 || e !== 1'b1) begin
      errors++; $display("FAIL empty_pop: lat=%0d data=%h err=%b expected lat=2 data=0 err=1", lat, d, e);
    end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d; logic e; int lat;
    logic [31:0] exp_words [3] = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    for (int i = 0; i < 3; i++) push_word(exp_words[i]);
    for (int i = 0; i < 3; i++) begin
      bus_read(11'd2, d, e, lat);
      checks++;
      if (lat !== 2 || d !== exp_words[i] || e !== 1'b0) begin
        errors++; $display("FAIL pop_order[%0d]: lat=%0d data=%h err=%b expected lat=2 data=%h err=0", i, lat, d, e, exp_words[i]);
      end
    end
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0001_0000 || e !== 1'b0) begin
      errors++; $display("FAIL status_drained: got %h err=%b expected 00010000", d, e);
    end
  endtask

  task automatic test_full_overflow();
    logic [31:0] d; logic e; int lat; logic wd;
    for (int i = 1; i <= 4; i++) push_word(32'hB000_0000 + 32'(i));
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_after_4: got %b expected 1", full); end
    push_word(32'hB000_0005);
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0006_0004) begin errors++; $display("FAIL status_full_ovf: got %h expected 00060004", d); end
    bus_read(11'd3, d, e, lat);
    checks++;
`ifdef FIFO_TARGET_OVF_CNT_EN
    if (lat !== 1 || d !== 32'd1 || e !== 1'b0) begin
      errors++; $display("FAIL ovf_count: lat=%0d data=%h err=%b expected lat=1 data=1 err=0", lat, d, e);
    end
`else
    if (lat !== 1 || d !== 32'd0 || e !== 1'b1) begin
      errors++; $display("FAIL ovf_unmapped: lat=%0d data=%h err=%b expected lat=1 data=0 err=1", lat, d, e);
    end
`endif
    bus_read(11'd2, d, e, lat);
    checks++;
    if (d !== 32'hB000_0001 || e !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL pop_from_full: data=%h err=%b full=%b expected B0000001 0 0", d, e, full);
    end
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0004_0003) begin errors++; $display("FAIL status_after_pop: got %h expected 00040003", d); end
    bus_write(11'd1, 32'h0000_0005, wd, e);
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0001_0000) begin errors++; $display("FAIL status_clear_ovfclr: got %h expected 00010000", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d; logic e; int lat; logic wd;
    bus_write(11'd1, 32'h0002_0002, wd, e);
    checks++;
    if (wd !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL ctrl_write: done=%b err=%b expected 1 0", wd, e); end
    bus_read(11'd1, d, e, lat);
    checks++;
    if (d !== 32'h0002_0002 || e !== 1'b0) begin errors++; $display("FAIL ctrl_readback: got %h expected 00020002", d); end
    push_word(32'hC000_0001);
    push_word(32'hC000_0002);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
    bus_read(11'd2, d, e, lat);
    checks++;
    if (irq !== 1'b0 || d !== 32'hC000_0001) begin
      errors++; $display("FAIL irq_fall: irq=%b data=%h expected 0 C0000001", irq, d);
    end
    bus_read(11'd2, d, e, lat);
    bus_write(11'd1, 32'h0000_0000, wd, e);
  endtask

  task automatic test_push_pop_same_cycle();
    logic [31:0] d; logic e; int lat;
    push = 1'b1; push_data = 32'h5A5A_0001;
    bus_if.VMEAddr = 11'd2; bus_if.VMERdMem = 1'b1;
    @(posedge clk); #1;
    push = 1'b0; bus_if.VMERdMem = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.VMERdDone !== 1'b1 || bus_if.VMERdError !== 1'b1 || bus_if.VMERdData !== 32'd0) begin
      errors++; $display("FAIL empty_pushpop: done=%b err=%b data=%h expected 1 1 0",
        bus_if.VMERdDone, bus_if.VMERdError, bus_if.VMERdData);
    end
    @(posedge clk); #1;
    push = 1'b1; push_data = 32'h5A5A_0002;
    bus_if.VMEAddr = 11'd2; bus_if.VMERdMem = 1'b1;
    @(posedge clk); #1;
    push = 1'b0; bus_if.VMERdMem = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.VMERdDone !== 1'b1 || bus_if.VMERdError !== 1'b0 || bus_if.VMERdData !== 32'h5A5A_0001) begin
      errors++; $display("FAIL pushpop_data: done=%b err=%b data=%h expected 1 0 5A5A0001",
        bus_if.VMERdDone, bus_if.VMERdError, bus_if.VMERdData);
    end
    @(posedge clk); #1;
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL pushpop_level: got %h expected 00000001", d); end
    bus_read(11'd2, d, e, lat);
    checks++;
    if (d !== 32'h5A5A_0002 || e !== 1'b0) begin errors++; $display("FAIL pushpop_second: got %h expected 5A5A0002", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d; logic e; int lat;
    for (int i = 1; i <= 3; i++) push_word(32'hD000_0000 + 32'(i));
    push = 1'b1; push_data = 32'hDEAD_0000;
    bus_if.VMEAddr = 11'd1; bus_if.VMEWrData = 32'h0000_0001; bus_if.VMEWrMem = 1'b1;
    @(posedge clk); #1;
    bus_if.VMEWrMem = 1'b0; push_data = 32'hC0FF_EE01;
    checks++;
    if (bus_if.VMEWrDone !== 1'b1 || bus_if.VMEWrError !== 1'b0) begin
      errors++; $display("FAIL clear_write: done=%b err=%b expected 1 0", bus_if.VMEWrDone, bus_if.VMEWrError);
    end
    @(posedge clk); #1;
    push = 1'b0;
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL clear_status: got %h expected 00000001", d); end
    bus_read(11'd2, d, e, lat);
    checks++;
    if (d !== 32'hC0FF_EE01 || e !== 1'b0) begin errors++; $display("FAIL clear_next_push: got %h expected C0FFEE01", d); end
`ifdef FIFO_TARGET_OVF_CNT_EN
    bus_read(11'd3, d, e, lat);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL clear_ovf_count: got %h expected 1", d); end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat; logic wd;
    bus_read(11'h7FF, d, e, lat);
    checks++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: lat=%0d err=%b data=%h expected 1 1 0", lat, e, d);
    end
    bus_write(11'd0, 32'hFFFF_FFFF, wd, e);
    checks++;
    if (wd !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL status_write: done=%b err=%b expected 1 1", wd, e); end
    bus_write(11'd2, 32'h1234_5678, wd, e);
    checks++;
    if (wd !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL data_write: done=%b err=%b expected 1 1", wd, e); end
    bus_read(11'd0, d, e, lat);
    checks++;
    if (d !== 32'h0001_0000 || e !== 1'b0) begin errors++; $display("FAIL status_unchanged: got %h expected 00010000", d); end
    bus_write(11'd1, 32'h0003_0007, wd, e);
    bus_read(11'd1, d, e, lat);
    checks++;
    if (d !== 32'h0003_0002) begin errors++; $display("FAIL ctrl_pulse_bits: got %h expected 00030002", d); end
  endtask

  initial begin
    bus_if.VMEAddr   = '0;
    bus_if.VMEWrData = '0;
    bus_if.VMERdMem  = 1'b0;
    bus_if.VMEWrMem  = 1'b0;
    test_reset();
    test_fifo_order();
    test_full_overflow();
    test_irq();
    test_push_pop_same_cycle();
    test_clear();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
